fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port run, input, 1 bit: fetch enable.
REQ-004 SHALL have port mem_address, output, 4 bits: RAM word address.
REQ-005 SHALL have port mem_rd, output, 1 bit: RAM read strobe.
REQ-006 SHALL have port mem_data, input, 8 bits: RAM read data, valid the cycle after mem_rd.
REQ-007 SHALL have port instr, output, 8 bits: fetched instruction byte (opcode [7:4], operando [3:0]).
REQ-008 SHALL have port instr_valid, output, 1 bit: instr holds an unconsumed instruction.
REQ-009 SHALL have port instr_ready, input, 1 bit: control unit accepts instr.
REQ-010 SHALL have port jump_valid, input, 1 bit: load PC request.
REQ-011 SHALL have port jump_target, input, 4 bits: new PC value.
REQ-012 SHALL have port pc, output, 4 bits: address of the next fetch.
REQ-013 SHALL have port halted, output, 1 bit: high in state HALT.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT, HOLD, HALT.
REQ-015 IDLE: SHALL go to REQ when run=1, else stay.
REQ-016 REQ: SHALL drive mem_rd=1, mem_address=pc for exactly one cycle, then go to WAIT; mem_rd SHALL be 0 in every other state.
REQ-017 WAIT: SHALL register mem_data into instr, increment pc modulo 16 (15 -> 0), go to HOLD.
REQ-018 HOLD: SHALL hold instr_valid=1 and instr stable until a cycle with instr_ready=1 (handshake).
REQ-019 On handshake SHALL drop instr_valid next cycle and go to REQ if run=1, IDLE if run=0.
REQ-020 run deasserted in REQ, WAIT or HOLD SHALL NOT abort the fetch in progress; it only takes effect at the handshake.
REQ-021 Minimum throughput SHALL be one instruction per 3 cycles with instr_ready tied high.
REQ-022 jump_valid=1 in any state SHALL load pc<=jump_target, clear instr_valid, discard any in-flight read data, and go to REQ if run=1, else IDLE.
REQ-023 jump_valid coincident with a handshake: jump SHALL win; the handshake instruction counts as consumed; next fetch is from jump_target.
REQ-024 HALT: outputs instr_valid=0, mem_rd=0, halted=1; exit only via jump_valid or reset; run ignored.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, pc=0, instr=8'h00, instr_valid=0, mem_rd=0, mem_address=0, halted=0.
REQ-026 Reset asserted mid-fetch SHALL discard the fetch; after release, fetching restarts from address 0.

Configuration
REQ-027 Macro FETCH_HALT_DETECT_EN defined: instruction with opcode 4'hF SHALL be presented normally in HOLD, and after its handshake the FSM SHALL go to HALT instead of REQ/IDLE.
REQ-028 Macro FETCH_HALT_DETECT_EN undefined: opcode 4'hF SHALL be treated like any other; HALT unreachable; halted tied 0.

Structure
REQ-029 Shared package proc_pkg SHALL hold ADDR_W=4, DATA_W=8, HALT_OPCODE=4'hF and the fetch state enum type.
REQ-030 PC (load/increment/wrap) SHALL be a sub-module pc_counter; the FSM and instr register remain in fetch_unit.

Verification
REQ-031 RAM[0..2]=8'h12,8'h34,8'h56, run=1, instr_ready=1 -> instr 12,34,56 on instr_valid at cycles 3,6,9 after reset release; pc 1,2,3.
REQ-032 instr_ready=0 for 5 cycles while instr=8'h12 valid -> instr_valid and instr stable, mem_rd=0, pc=1 throughout; fetch of address 1 starts the cycle after the handshake.
REQ-033 pc=15, RAM[15]=8'hA7, RAM[0]=8'h12 -> instr A7 then 12; pc wraps 15->0->1.
REQ-034 jump_valid=1, jump_target=4'h9 during WAIT of address 2 -> address-2 data never presented; next mem_rd with mem_address=9.
REQ-035 FETCH_HALT_DETECT_EN defined, RAM[1]=8'hF0 -> F0 presented, after its handshake halted=1, mem_rd stays 0 for 20 cycles; jump to 0 restarts fetch at address 0.
REQ-036 reset asserted during HOLD with instr=8'h34 -> instr_valid, mem_rd, pc drop to 0 without a clock edge; after release first mem_address=0.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, halt opcode and fetch FSM state type
// Contents: ADDR_W (RAM word address width), DATA_W (instruction width),
//           HALT_OPCODE (opcode that stops fetching when halt detection is built in),
//           fetch_state_t (fetch FSM states).
package proc_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam logic [3:0] HALT_OPCODE = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: RAM read port, instruction handshake and jump request of the fetch unit
// Signals: run (fetch enable), mem_address/mem_rd/mem_data (RAM read, data one cycle after rd),
//          instr/instr_valid/instr_ready (instruction handshake), jump_valid/jump_target (PC load),
//          pc (next fetch address), halted (fetch stopped on halt opcode).
// Modports: master = fetch unit side, slave = RAM / control unit side.
interface fetch_unit_if;
  import proc_pkg::*;
  logic              run;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  modport master (
    input  run, mem_data, instr_ready, jump_valid, jump_target,
    output mem_address, mem_rd, instr, instr_valid, pc, halted
  );
  modport slave (
    output run, mem_data, instr_ready, jump_valid, jump_target,
    input  mem_address, mem_rd, instr, instr_valid, pc, halted
  );
endinterface

// File: rtl/pc_counter.sv
// pc_counter: program counter with load and modulo-16 increment
// Ports: clock, reset (async active-low), load_i/load_value_i (load has priority),
//        inc_i (advance by one, wrapping 15 -> 0), pc_o (current value).
module pc_counter
  import proc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_value_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  always_comb pc_d = load_i ? load_value_i : inc_i ? pc_q + 1'b1 : pc_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) pc_q <= '0;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM (IDLE/REQ/WAIT/HOLD/HALT) with instruction register
// Ports: clock, reset (async active-low), bus (fetch_unit_if.master: RAM read port,
//        instruction valid/ready handshake, jump request, pc and halted status).
// Build option: FETCH_HALT_DETECT_EN enables stopping in HALT after an opcode-F instruction
//               is consumed; without it halted is tied low and HALT is never entered.
module fetch_unit
  import proc_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);
  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              capture, handshake, halt_op;
  // a jump in WAIT drops the returning read data instead of capturing it
  assign capture   = state_q == S_WAIT && !bus.jump_valid;
  assign handshake = state_q == S_HOLD && bus.instr_ready;
`ifdef FETCH_HALT_DETECT_EN
  assign halt_op    = instr_q[DATA_W-1 -: 4] == HALT_OPCODE;
  assign bus.halted = state_q == S_HALT;
`else
  assign halt_op    = 1'b0;
  assign bus.halted = 1'b0;
`endif
  // jump overrides every state, including a coincident handshake
  always_comb begin
    state_d = state_q;
    if (bus.jump_valid) state_d = bus.run ? S_REQ : S_IDLE;
    else
      case (state_q)
        S_IDLE:  state_d = bus.run ? S_REQ : S_IDLE;
        S_REQ:   state_d = S_WAIT;
        S_WAIT:  state_d = S_HOLD;
        S_HOLD:  state_d = !handshake ? S_HOLD : halt_op ? S_HALT : bus.run ? S_REQ : S_IDLE;
        default: state_d = state_q;
      endcase
  end
  always_comb instr_d = capture ? bus.mem_data : instr_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  pc_counter u_pc (
    .clock        (clock),
    .reset        (reset),
    .load_i       (bus.jump_valid),
    .load_value_i (bus.jump_target),
    .inc_i        (capture),
    .pc_o         (bus.pc)
  );
  assign bus.mem_rd      = state_q == S_REQ;
  assign bus.mem_address = bus.pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = state_q == S_HOLD;
endmodule
